ptw_axi_read_port: RTL and testbench

Shared page-table-walk read port between the instruction TLB, the data TLB and the AXI4 read channel.
- Each TLB issues single-cycle PTE fetch requests.
- The block latches them and arbitrates between the two sides.
- It issues one 8-byte AXI4 read per request and returns the PTE on a single-cycle data-valid pulse to the originating TLB.
- It sits directly downstream of both TLBs' AXI address outputs and upstream of their data-from-AXI inputs.

---
 rtl/ptw_axi_read_port.sv | 138 +++++++++++++
 tb/tb_ptw_axi_read_port.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_axi_read_port.sv
// Shared page-table-walk read port: latches ITLB/DTLB PTE fetches, arbitrates D over I,
// and issues one single-beat AXI4 read per walk, steering the PTE back to the requester.
module ptw_axi_read_port #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int I_ID       = 0,
    parameter int D_ID       = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  I_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] I_ADDR,
    output logic                  I_DATA_VALID,
    output logic [DATA_WIDTH-1:0] I_DATA,
    output logic                  I_ERR,
    input  logic                  D_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] D_ADDR,
    output logic                  D_DATA_VALID,
    output logic [DATA_WIDTH-1:0] D_DATA,
    output logic                  D_ERR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [ID_WIDTH-1:0]   ARID,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

    state_t                state_q, state_d;
    logic                  i_vld_q, d_vld_q;
    logic [ADDR_WIDTH-1:0] i_addr_q, d_addr_q;
    logic                  sel_d_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [ID_WIDTH-1:0]   arid_q;
    logic [DATA_WIDTH-1:0] i_data_q, d_data_q;
    logic                  i_err_q, d_err_q, i_dv_q, d_dv_q;
    logic                  ar_load, r_fire, r_err;

    // Single-beat reads only: RLAST carries no information here.
    logic unused_rlast;
    assign unused_rlast = RLAST;

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_vld_q || d_vld_q) state_d = S_AR;
            S_AR:    if (ARREADY)            state_d = S_R;
            S_R:     if (RVALID)             state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ARVALID = (state_q == S_AR);
        RREADY  = (state_q == S_R);
        ar_load = (state_q == S_IDLE) && (i_vld_q || d_vld_q);
        r_fire  = (state_q == S_R) && RVALID;
        r_err   = (RRESP != 2'b00);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            i_vld_q  <= 1'b0;
            d_vld_q  <= 1'b0;
            i_addr_q <= '0;
            d_addr_q <= '0;
            sel_d_q  <= 1'b0;
            araddr_q <= '0;
            arid_q   <= '0;
            i_data_q <= '0;
            d_data_q <= '0;
            i_err_q  <= 1'b0;
            d_err_q  <= 1'b0;
            i_dv_q   <= 1'b0;
            d_dv_q   <= 1'b0;
        end else begin
            i_dv_q <= 1'b0;
            d_dv_q <= 1'b0;
            // A pulse into an occupied slot is dropped, including on its completion edge.
            if (I_ADDR_VALID && !i_vld_q) begin
                i_vld_q  <= 1'b1;
                i_addr_q <= I_ADDR;
            end else if (r_fire && !sel_d_q) begin
                i_vld_q <= 1'b0;
            end
            if (D_ADDR_VALID && !d_vld_q) begin
                d_vld_q  <= 1'b1;
                d_addr_q <= D_ADDR;
            end else if (r_fire && sel_d_q) begin
                d_vld_q <= 1'b0;
            end
            if (ar_load) begin
                sel_d_q  <= d_vld_q;
                araddr_q <= d_vld_q ? d_addr_q : i_addr_q;
                arid_q   <= d_vld_q ? ID_WIDTH'(D_ID) : ID_WIDTH'(I_ID);
            end
            // Steer by the side latched at arbitration, never by RID.
            if (r_fire) begin
                if (sel_d_q) begin
                    d_data_q <= r_err ? '0 : RDATA;
                    d_err_q  <= r_err;
                    d_dv_q   <= 1'b1;
                end else begin
                    i_data_q <= r_err ? '0 : RDATA;
                    i_err_q  <= r_err;
                    i_dv_q   <= 1'b1;
                end
            end
        end
    end

    assign ARADDR       = araddr_q;
    assign ARID         = arid_q;
    assign ARLEN        = 8'd0;
    assign ARSIZE       = 3'd3;
    assign ARBURST      = 2'd1;
    assign I_DATA_VALID = i_dv_q;
    assign I_DATA       = i_data_q;
    assign I_ERR        = i_err_q;
    assign D_DATA_VALID = d_dv_q;
    assign D_DATA       = d_data_q;
    assign D_ERR        = d_err_q;

endmodule

// File: tb/tb_ptw_axi_read_port.sv
// Bench for ptw_axi_read_port: table of walks plus hand sequences, with an AXI slave
// model and queues of expected AR beats and PTE returns.
module tb_ptw_axi_read_port;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        I_ADDR_VALID = 1'b0, D_ADDR_VALID = 1'b0;
    logic [63:0] I_ADDR = '0, D_ADDR = '0;
    logic        I_DATA_VALID, D_DATA_VALID, I_ERR, D_ERR;
    logic [63:0] I_DATA, D_DATA;
    logic        ARVALID, ARREADY = 1'b1;
    logic [63:0] ARADDR;
    logic [3:0]  ARID;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        RVALID = 1'b0, RREADY, RLAST = 1'b1;
    logic [63:0] RDATA = '0;
    logic [1:0]  RRESP = '0;

    ptw_axi_read_port dut (
        .CLK(CLK), .RST(RST),
        .I_ADDR_VALID(I_ADDR_VALID), .I_ADDR(I_ADDR), .I_DATA_VALID(I_DATA_VALID),
        .I_DATA(I_DATA), .I_ERR(I_ERR),
        .D_ADDR_VALID(D_ADDR_VALID), .D_ADDR(D_ADDR), .D_DATA_VALID(D_DATA_VALID),
        .D_DATA(D_DATA), .D_ERR(D_ERR),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID),
        .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [63:0] addr; logic [3:0] id; } ar_t;
    typedef struct { logic [63:0] data; logic [1:0] resp; } rsp_t;
    typedef struct { bit side; logic [63:0] data; bit err; int t0; int lat; } exp_t;
    typedef struct {
        bit ip, dp; logic [63:0] ia, da;
        logic [63:0] rd_a; logic [1:0] rr_a; logic [63:0] rd_b; logic [1:0] rr_b;
        int arw;
        bit e_first_d; logic [63:0] e_dat_a; bit e_err_a; logic [63:0] e_dat_b; bit e_err_b;
        int e_lat_a;
    } vec_t;

    ar_t  ar_q[$];
    rsp_t rsp_q[$];
    exp_t exp_q[$];
    int n_chk = 0, n_fail = 0, cyc = 0;
    int ar_wait = 0, r_wait = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc++;

    // AXI slave: ARREADY stall of ar_wait cycles, RVALID delayed r_wait cycles after RREADY.
    initial begin
        bit ar_hs, r_hs, rst_s, ar_seen, r_pend;
        int ar_cnt, rw_cnt;
        ar_seen = 0; r_pend = 0; ar_cnt = 0; rw_cnt = 0;
        forever begin
            @(negedge CLK);
            ar_hs = ARVALID && ARREADY;
            r_hs  = RVALID && RREADY;
            rst_s = RST;
            @(posedge CLK); #1;
            if (rst_s) begin
                RVALID = 0; r_pend = 0; ar_seen = 0; ARREADY = 1;
            end else begin
                if (ARVALID && !ar_seen) begin ar_seen = 1; ar_cnt = ar_wait; end
                if (ARVALID) begin
                    if (ar_cnt > 0) begin ARREADY = 0; ar_cnt--; end
                    else ARREADY = 1;
                end else begin
                    ARREADY = 1; ar_seen = 0;
                end
                if (r_hs) begin
                    RVALID = 0; r_pend = 0;
                    if (rsp_q.size() != 0) void'(rsp_q.pop_front());
                end
                if (ar_hs) begin r_pend = 1; rw_cnt = r_wait; end
                if (r_pend && RREADY && !RVALID) begin
                    if (rw_cnt > 0) rw_cnt--;
                    else begin
                        RVALID = 1;
                        RDATA  = (rsp_q.size() != 0) ? rsp_q[0].data : 64'h0;
                        RRESP  = (rsp_q.size() != 0) ? rsp_q[0].resp : 2'b00;
                    end
                end
            end
        end
    end

    // Monitor: AR beats, AR stability under stall, PTE returns.
    logic        stall_prev = 0;
    logic [63:0] p_addr;
    logic [3:0]  p_id;
    always @(negedge CLK) begin
        if (RST) stall_prev = 0;
        else begin
            if (stall_prev) chk("ar_stable", {ARVALID, ARADDR, ARID}, {1'b1, p_addr, p_id});
            stall_prev = ARVALID && !ARREADY;
            p_addr = ARADDR; p_id = ARID;
            if (ARVALID && ARREADY) begin
                if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
                else begin
                    ar_t a;
                    a = ar_q.pop_front();
                    chk("araddr", ARADDR, a.addr);
                    chk("arid", ARID, a.id);
                end
            end
            if (I_DATA_VALID || D_DATA_VALID) begin
                if (exp_q.size() == 0) chk("dv_unexpected", {I_DATA_VALID, D_DATA_VALID}, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dv_side", {I_DATA_VALID, D_DATA_VALID}, e.side ? 2'b01 : 2'b10);
                    chk("pte_data", e.side ? D_DATA : I_DATA, e.data);
                    chk("pte_err", e.side ? D_ERR : I_ERR, e.err);
                    if (e.lat != 0) chk("latency", cyc - e.t0, e.lat);
                end
            end
        end
    end

    task automatic expect_walk(bit side, logic [63:0] addr, logic [63:0] rd, logic [1:0] rr,
                               logic [63:0] ed, bit ee, int t0, int lat);
        ar_t a; rsp_t r; exp_t e;
        a.addr = addr; a.id = side ? 4'd1 : 4'd0;
        r.data = rd; r.resp = rr;
        e.side = side; e.data = ed; e.err = ee; e.t0 = t0; e.lat = lat;
        ar_q.push_back(a); rsp_q.push_back(r); exp_q.push_back(e);
    endtask

    // Called at posedge+#1; holds the pulse for exactly one cycle.
    task automatic pulse(bit ip, logic [63:0] ia, bit dp, logic [63:0] da);
        I_ADDR_VALID = ip; I_ADDR = ia; D_ADDR_VALID = dp; D_ADDR = da;
        @(posedge CLK); #1;
        I_ADDR_VALID = 0; D_ADDR_VALID = 0;
    endtask

    task automatic wait_done(string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge CLK); n++; end
        chk({nm, "_timeout"}, exp_q.size() == 0, 1);
        repeat (4) @(posedge CLK);
        #1;
        chk({nm, "_ar_left"}, ar_q.size(), 0);
    endtask

    task automatic wait_rready(string nm);
        int n = 0;
        while (!RREADY && n < 50) begin @(posedge CLK); #1; n++; end
        chk({nm, "_reach_r"}, RREADY, 1);
    endtask

    task automatic check_zero(string nm);
        chk({nm, "_arvalid"}, ARVALID, 0);
        chk({nm, "_rready"}, RREADY, 0);
        chk({nm, "_dv"}, {I_DATA_VALID, D_DATA_VALID}, 0);
        chk({nm, "_err"}, {I_ERR, D_ERR}, 0);
        chk({nm, "_araddr"}, ARADDR, 0);
        chk({nm, "_arid"}, ARID, 0);
        chk({nm, "_idata"}, I_DATA, 0);
        chk({nm, "_ddata"}, D_DATA, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    vec_t vec[6];

    initial begin
        vec[0] = '{1, 0, 64'h80001008, 64'h0, 64'h20000C01, 2'd0, 64'h0, 2'd0, 0,
                   0, 64'h20000C01, 0, 64'h0, 0, 4};
        vec[1] = '{1, 1, 64'h1000, 64'h2000, 64'h2222, 2'd0, 64'h1111, 2'd0, 0,
                   1, 64'h2222, 0, 64'h1111, 0, 4};
        vec[2] = '{0, 1, 64'h0, 64'h3000, 64'hABCD, 2'd0, 64'h0, 2'd0, 5,
                   1, 64'hABCD, 0, 64'h0, 0, 9};
        vec[3] = '{1, 0, 64'h4000, 64'h0, 64'hFFFF, 2'd2, 64'h0, 2'd0, 0,
                   0, 64'h0, 1, 64'h0, 0, 4};
        vec[4] = '{0, 1, 64'h0, 64'h4800, 64'h1234, 2'd3, 64'h0, 2'd0, 0,
                   1, 64'h0, 1, 64'h0, 0, 4};
        vec[5] = '{1, 1, 64'h9000, 64'h9800, 64'hDEAD, 2'd2, 64'hBEEF, 2'd0, 2,
                   1, 64'h0, 1, 64'hBEEF, 0, 6};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_zero("reset");
        chk("arlen", ARLEN, 0);
        chk("arsize", ARSIZE, 3);
        chk("arburst", ARBURST, 1);
        @(posedge CLK); #1;
        RST = 0;
        repeat (2) @(posedge CLK); #1;

        for (int k = 0; k < 6; k++) begin
            bit sa;
            sa = vec[k].e_first_d;
            ar_wait = vec[k].arw;
            expect_walk(sa, sa ? vec[k].da : vec[k].ia, vec[k].rd_a, vec[k].rr_a,
                        vec[k].e_dat_a, vec[k].e_err_a, cyc, vec[k].e_lat_a);
            if (vec[k].ip && vec[k].dp)
                expect_walk(!sa, sa ? vec[k].ia : vec[k].da, vec[k].rd_b, vec[k].rr_b,
                            vec[k].e_dat_b, vec[k].e_err_b, cyc, 0);
            pulse(vec[k].ip, vec[k].ia, vec[k].dp, vec[k].da);
            wait_done($sformatf("vec%0d", k));
        end
        ar_wait = 0;

        // Duplicate I pulse while the I walk sits in R: dropped, no second AR.
        r_wait = 3;
        expect_walk(0, 64'h5000, 64'h5A5A, 2'd0, 64'h5A5A, 0, cyc, 0);
        pulse(1, 64'h5000, 0, 64'h0);
        wait_rready("dup");
        pulse(1, 64'h5555, 0, 64'h0);
        wait_done("dup");
        repeat (6) @(posedge CLK); #1;
        chk("dup_no_extra_ar", ar_q.size() + exp_q.size(), 0);

        // Reset while in R abandons the walk with no pulse.
        r_wait = 4;
        expect_walk(0, 64'h6000, 64'h6666, 2'd0, 64'h6666, 0, cyc, 0);
        pulse(1, 64'h6000, 0, 64'h0);
        wait_rready("rst");
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        rsp_q.delete();
        exp_q.delete();
        @(negedge CLK);
        check_zero("rst_in_r");
        r_wait = 0;
        @(posedge CLK); #1;
        expect_walk(1, 64'h7000, 64'h7777, 2'd0, 64'h7777, 0, cyc, 4);
        pulse(0, 64'h0, 1, 64'h7000);
        wait_done("post_rst");

        repeat (4) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
